div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have rst, input, 1: reset rst, synchronous, active-high.
REQ-003 SHALL have signed_div_i, input, 1: 1 = signed (div), 0 = unsigned (divu); sampled with start_i in DIV_FREE.
REQ-004 SHALL have opdata1_i, input, 32: dividend; sampled with start_i in DIV_FREE.
REQ-005 SHALL have opdata2_i, input, 32: divisor; sampled with start_i in DIV_FREE.
REQ-006 SHALL have start_i, input, 1: divide request from EX; held high until ready_o is seen.
REQ-007 SHALL have annul_i, input, 1: cancel the in-flight divide; driven from the pipeline flush.
REQ-008 SHALL have result_o, output, 64: {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have ready_o, output, 1: result_o is valid.
REQ-010 SHALL have stallreq_o, output, 1: combinational request to stall the pipeline through the EX stage.

Function
REQ-011 SHALL implement the FSM states DIV_FREE, DIV_BYZERO, DIV_ON and DIV_END.
REQ-012 In DIV_FREE with start_i=1 and annul_i=0, the FSM SHALL go to DIV_BYZERO if opdata2_i==0, else to DIV_ON, and SHALL clear the iteration counter to 0.
REQ-013 In DIV_FREE, if start_i=0 or annul_i=1, the FSM SHALL stay in DIV_FREE.
REQ-014 When signed_div_i=1, the block SHALL latch the two's-complement magnitude of any negative operand; otherwise it SHALL latch the raw operands.
REQ-015 DIV_ON SHALL perform one shift-subtract step per cycle on a 65-bit working register, running exactly 32 steps.
REQ-016 On the 32nd step, DIV_ON SHALL go to DIV_END.
REQ-017 Final sign fix-up when signed: quotient SHALL be negated if opdata1[31] XOR opdata2[31]; remainder SHALL be negated if opdata1[31].
REQ-018 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-019 DIV_BYZERO SHALL load a zero result and go to DIV_END on the next cycle.
REQ-020 In any state except DIV_END, annul_i=1 SHALL force DIV_FREE on the next edge, with ready_o=0 and result_o=0.
REQ-021 In DIV_END, ready_o SHALL be 1 and result_o SHALL hold the result; start_i=0 SHALL move the FSM to DIV_FREE and zero both outputs on the next edge.
REQ-022 In DIV_END with start_i=1, the FSM SHALL hold; a new divide SHALL need start_i low for at least one cycle.
REQ-023 Outside DIV_END, ready_o SHALL be 0 and result_o SHALL be 0.
REQ-024 stallreq_o SHALL equal start_i AND NOT ready_o AND NOT annul_i.
REQ-025 Latency, with start_i first high in cycle 0 and a non-zero divisor: ready_o SHALL be high in cycle 33, and stallreq_o SHALL be high in cycles 0..32.
REQ-026 Latency with a zero divisor: ready_o SHALL be high in cycle 2.
REQ-027 Operand changes after the start_i sampling edge SHALL NOT affect the result.

Reset
REQ-028 With rst=1 at a rising edge, the block SHALL enter DIV_FREE and clear the counter, ready_o, result_o and the working register.
REQ-029 rst SHALL take priority over annul_i and start_i, including in the middle of DIV_ON.

Structure
REQ-030 The state encodings, DivResultReady/NotReady, DivStart/Stop and the 32-step count constant SHALL live in the shared defines file.
REQ-031 The block SHALL be a single module; no sub-module is natural, and the shift-subtract step SHALL be inline.

Verification
REQ-032 Unsigned 100/7, start_i in cycle 0 -> ready_o in cycle 33, result_o = {0x00000002, 0x0000000E}; stallreq_o high in cycles 0..32.
REQ-033 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-034 Divisor 0 -> ready_o in cycle 2, result_o = 0, FSM passes through DIV_BYZERO.
REQ-035 annul_i pulse in cycle 10 -> DIV_FREE in cycle 11, ready_o never rises; a fresh start afterwards computes correctly.
REQ-036 rst asserted in cycle 15 of DIV_ON -> DIV_FREE and all outputs 0 in the next cycle.
REQ-037 start_i held high through DIV_END for 5 cycles -> result held stable; after start_i drops -> DIV_FREE and a back-to-back divide succeeds.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: FSM state encodings,
// handshake levels and the shift-subtract step count.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam int unsigned DIV_STEPS = 32;

endpackage

// File: rtl/div_unit.sv
// 32-bit signed/unsigned radix-2 restoring divider, 32 steps per divide.
// Result is {remainder, quotient}, held while start_i stays high.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    div_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        signed_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic        ready_q;
    logic [63:0] result_q;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [65:0] shifted;
    logic [33:0] diff;
    logic [64:0] work_d;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // work register: partial remainder in [64:32], dividend/quotient bits in [31:0]
    always_comb begin
        op1_abs = opdata1_i;
        op2_abs = opdata2_i;
        if (signed_div_i && opdata1_i[31]) op1_abs = (~opdata1_i) + 32'd1;
        if (signed_div_i && opdata2_i[31]) op2_abs = (~opdata2_i) + 32'd1;

        shifted = {work_q, 1'b0};
        diff    = shifted[65:32] - {2'b00, divisor_q};
        work_d  = shifted[64:0];
        if (!diff[33]) begin
            work_d[64:32] = diff[32:0];
            work_d[0]     = 1'b1;
        end

        quot_raw = work_d[31:0];
        rem_raw  = work_d[63:32];
        quot_fix = (signed_q && neg_quot_q) ? (~quot_raw) + 32'd1 : quot_raw;
        rem_fix  = (signed_q && neg_rem_q)  ? (~rem_raw)  + 32'd1 : rem_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_q    <= DivResultNotReady;
            result_q   <= '0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    ready_q  <= DivResultNotReady;
                    result_q <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        state_q    <= (opdata2_i == 32'd0) ? DIV_BYZERO : DIV_ON;
                        cnt_q      <= '0;
                        work_q     <= {33'd0, op1_abs};
                        divisor_q  <= op2_abs;
                        signed_q   <= signed_div_i;
                        neg_quot_q <= opdata1_i[31] ^ opdata2_i[31];
                        neg_rem_q  <= opdata1_i[31];
                    end
                end
                DIV_BYZERO: begin
                    result_q <= '0;
                    if (annul_i) begin
                        state_q <= DIV_FREE;
                        ready_q <= DivResultNotReady;
                    end else begin
                        state_q <= DIV_END;
                        ready_q <= DivResultReady;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_q  <= DIV_FREE;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 6'd1;
                        // last step: sign fix-up is applied on the fly from this step's result
                        if (cnt_q == 6'(DIV_STEPS - 1)) begin
                            state_q  <= DIV_END;
                            ready_q  <= DivResultReady;
                            result_q <= {rem_fix, quot_fix};
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DivStop) begin
                        state_q  <= DIV_FREE;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q  <= DIV_FREE;
                    ready_q  <= DivResultNotReady;
                    result_q <= '0;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model checked every cycle,
// plus literal latency/result expectations for each directed vector.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division, remainder takes dividend's sign.
    function automatic logic [63:0] golden(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: a divide accepted at an edge produces its result after a fixed
    // number of further edges, is dropped by annul/rst, and is held while start stays high.
    logic        m_busy  = 1'b0;
    logic        m_ready = 1'b0;
    logic [63:0] m_res   = '0;
    logic [63:0] m_pend  = '0;
    int          m_left  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_res   <= '0;
        end else if (m_ready) begin
            if (!start_i) begin
                m_ready <= 1'b0;
                m_res   <= '0;
            end
        end else if (m_busy) begin
            if (annul_i) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_res   <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start_i && !annul_i) begin
            m_busy <= 1'b1;
            m_left <= (opdata2_i == 32'd0) ? 1 : 32;
            m_pend <= golden(signed_div_i, opdata1_i, opdata2_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {63'd0, ready_o}, {63'd0, m_ready});
            chk("result", result_o, m_res);
            chk("stall", {63'd0, stallreq_o}, {63'd0, start_i & ~m_ready & ~annul_i});
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Start a divide in the current cycle (cycle 0), scramble operands after the
    // sampling edge, and measure the cycle in which ready_o first rises.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [63:0] exp_res, input string name);
        int cyc;
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            if (ready_o === 1'b1) break;
            if (cyc == 0) begin
                @(posedge clk);
                #1;
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sg;
            end
            cyc++;
        end
        chk({name, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({name, "_res"}, result_o, exp_res);
    endtask

    task automatic drop_start();
        next_cyc();
        start_i = 1'b0;
        next_cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        repeat (3) next_cyc();
        @(negedge clk);
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        next_cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        chk("model_u100_7", golden(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        chk("model_s_m7_2", golden(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("model_s_min_m1", golden(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        chk("model_by0", golden(1'b1, 32'd5, 32'd0), 64'd0);

        next_cyc();
        run_div(1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E, "u100_7");
        drop_start();
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD, "s_m7_2");
        drop_start();
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000, "s_min_m1");
        drop_start();
        run_div(1'b1, 32'd100, 32'hFFFFFFF9, 33, 64'h00000002_FFFFFFF2, "s_100_m7");
        drop_start();
        run_div(1'b0, 32'd1234, 32'd0, 2, 64'd0, "by0");
        drop_start();

        // annul in cycle 10 of a divide
        signed_div_i = 1'b0;
        opdata1_i = 32'd500;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (10) next_cyc();
        annul_i = 1'b1;
        start_i = 1'b0;
        next_cyc();
        annul_i = 1'b0;
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) rises++;
        end
        chk("annul_no_ready", 64'(rises), 64'd0);
        next_cyc();
        run_div(1'b0, 32'd500, 32'd3, 33, 64'h00000002_000000A6, "after_annul");
        drop_start();

        // reset in the middle of the iteration
        opdata1_i = 32'd1000;
        opdata2_i = 32'd9;
        start_i = 1'b1;
        repeat (15) next_cyc();
        rst = 1'b1;
        start_i = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("midrst_ready", {63'd0, ready_o}, 64'd0);
        chk("midrst_result", result_o, 64'd0);
        next_cyc();
        rst = 1'b0;
        next_cyc();

        // result held while start stays high, then back-to-back divide
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, 33, 64'h0000000F_0FFFFFFF, "hold");
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            @(negedge clk);
            chk("hold_ready", {63'd0, ready_o}, 64'd1);
            chk("hold_result", result_o, 64'h0000000F_0FFFFFFF);
        end
        drop_start();
        run_div(1'b0, 32'd77, 32'd77, 33, 64'h00000000_00000001, "b2b");
        drop_start();
        run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 64'hFFFFFFFF_00000003, "s_m7_m2");
        drop_start();

        repeat (2) next_cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
